// File: rtl/bus_fabric_pkg.sv
// Shared types and defaults for the bus_fabric CPU-to-slave bridge.
// The timeout counter only exists when BUS_FABRIC_TIMEOUT_EN is defined.
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int DEF_N_SLV   = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 15;

   // Slave i sits in bits [i*ADDR_W +: ADDR_W]; slave 0 is the rightmost word.
   localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE =
      {32'h0000_4000, 32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F000};
   localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_MASK =
      {32'hFFFF_C000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational region decoder: one-hot select of the lowest-index matching slave.
import bus_fabric_pkg::*;

module bus_addr_decoder #(
   parameter int N_SLV  = DEF_N_SLV,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [N_SLV-1:0]  sel,
   output logic              hit
);

   // Scanning from the top down lets a lower index overwrite a higher one.
   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            sel    = '0;
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus bridge: IDLE -> ACCESS -> RESP, unmapped addresses skip to RESP with err.
// Define BUS_FABRIC_TIMEOUT_EN to bound ACCESS to TIMEOUT cycles without an ack.
import bus_fabric_pkg::*;

module bus_fabric #(
   parameter int N_SLV   = DEF_N_SLV,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic                    cpu_ready,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_err,
   output logic [N_SLV-1:0]        slv_req,
   output logic                    slv_we,
   output logic [ADDR_W-1:0]       slv_addr,
   output logic [DATA_W-1:0]       slv_wdata,
   input  logic [N_SLV-1:0]        slv_ack,
   input  logic [N_SLV*DATA_W-1:0] slv_rdata,
   output logic [1:0]              state_dbg
);

   state_t            state;
   logic [N_SLV-1:0]  dec_sel;
   logic              dec_hit;
   logic [ADDR_W-1:0] dec_off;
   logic              ack_sel;
   logic [DATA_W-1:0] ack_rdata;
   logic              tmo_hit;

   bus_addr_decoder #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr (cpu_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   always_comb begin
      dec_off = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (dec_sel[i]) dec_off = cpu_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
      end
   end

   // slv_req is one-hot, so masking the ack bus with it drops foreign acks.
   assign ack_sel = |(slv_ack & slv_req);

   always_comb begin
      ack_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (slv_req[i]) ack_rdata = slv_rdata[i*DATA_W +: DATA_W];
      end
   end

`ifdef BUS_FABRIC_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT);
   logic [CNT_W-1:0] tmo_cnt;

   // tmo_cnt holds the number of ACCESS cycles already spent without an ack.
   always_ff @(posedge clk) begin
      if (rst || state != ACCESS) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + CNT_W'(1);
   end

   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = |32'(TIMEOUT);
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         slv_req   <= '0;
         slv_we    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         cpu_err   <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         cpu_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  slv_we    <= cpu_we;
                  slv_addr  <= dec_off;
                  slv_wdata <= cpu_wdata;
                  if (dec_hit) begin
                     slv_req <= dec_sel;
                     state   <= ACCESS;
                  end else begin
                     cpu_ready <= 1'b1;
                     cpu_err   <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            ACCESS: begin
               // An ack in the expiring cycle still completes cleanly.
               if (ack_sel) begin
                  slv_req   <= '0;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= slv_we ? '0 : ack_rdata;
                  state     <= RESP;
               end else if (tmo_hit) begin
                  slv_req   <= '0;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: transaction model, per-cycle compare, expected-data queue.
// Timeout scenarios run only when BUS_FABRIC_TIMEOUT_EN is defined.
module tb_bus_fabric;

   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic          cpu_ready, cpu_err;
   logic [31:0]   cpu_rdata;
   logic [3:0]    slv_req, slv_ack;
   logic          slv_we;
   logic [31:0]   slv_addr, slv_wdata;
   logic [127:0]  slv_rdata;
   logic [1:0]    state_dbg;

   logic [31:0]   ovl_addr;
   logic [2:0]    ovl_sel;
   logic          ovl_hit;

   always #5 clk = ~clk;

   bus_fabric u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_rdata (cpu_rdata),
      .cpu_err   (cpu_err),
      .slv_req   (slv_req),
      .slv_we    (slv_we),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_ack   (slv_ack),
      .slv_rdata (slv_rdata),
      .state_dbg (state_dbg)
   );

   // Overlapping regions: slave 2 matches everything, slaves 0 and 1 nest inside 0x1000.
   bus_addr_decoder #(
      .N_SLV    (3),
      .ADDR_W   (32),
      .SLV_BASE ({32'h0000_0000, 32'h0000_1000, 32'h0000_1000}),
      .SLV_MASK ({32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_FF00})
   ) u_ovl (
      .addr (ovl_addr),
      .sel  (ovl_sel),
      .hit  (ovl_hit)
   );

   // Address map as documented for the default build, slave 0 first.
   logic [31:0] base_tab [4] = '{32'hFFFF_F000, 32'hFFFF_F060, 32'hFFFF_F070, 32'h0000_4000};
   logic [31:0] mask_tab [4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_C000};

   int          n_checks = 0;
   int          n_err    = 0;
   logic [32:0] exp_q [$];

   logic        chk_en = 1'b0;
   logic        chk_slv;
   logic        exp_ready, exp_we, noise_all;
   logic [3:0]  exp_req;
   logic [31:0] exp_addr, exp_wdata;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_sel(input logic [31:0] a);
      for (int i = 0; i < 4; i++) begin
         if ((a & mask_tab[i]) == base_tab[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_exp(input logic [3:0] rq, input logic sl, input logic we,
                          input logic [31:0] ad, input logic [31:0] wd, input logic rdy);
      exp_req   = rq;
      chk_slv   = sl;
      exp_we    = we;
      exp_addr  = ad;
      exp_wdata = wd;
      exp_ready = rdy;
   endtask

   // Compare process: every cycle at the falling edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (chk_en) begin
         check("cpu_ready", 64'(cpu_ready), 64'(exp_ready));
         check("slv_req", 64'(slv_req), 64'(exp_req));
         if (chk_slv) begin
            check("slv_we", 64'(slv_we), 64'(exp_we));
            check("slv_addr", 64'(slv_addr), 64'(exp_addr));
            check("slv_wdata", 64'(slv_wdata), 64'(exp_wdata));
         end
         if (cpu_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_ready", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("cpu_rdata", 64'(cpu_rdata), 64'(e[31:0]));
               check("cpu_err", 64'(cpu_err), 64'(e[32]));
            end
         end else begin
            check("idle_rdata", 64'(cpu_rdata), 64'(0));
            check("idle_err", 64'(cpu_err), 64'(0));
         end
      end
   end

   // Called at #1 after an edge with the DUT idle; that cycle is cycle 1.
   // ack_delay = ACCESS cycles without an ack before the selected slave acks.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdv, input int ack_delay,
                          output int rc, output logic [31:0] rd, output logic er,
                          output logic [31:0] off_seen);
      int          s, d;
      logic        tmo, miss;
      logic [31:0] off, data;
      s    = model_sel(addr);
      miss = (s < 0);
      tmo  = 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      if (!miss && ack_delay > TMO - 1) tmo = 1'b1;
`endif
      d    = miss ? 1 : (tmo ? 1 + TMO : 2 + ack_delay);
      off  = miss ? 32'h0 : (addr & ~mask_tab[s]);
      data = (miss || tmo || we) ? 32'h0 : rdv;
      exp_q.push_back({miss || tmo, data});
      rc = 0; rd = '0; er = 1'b0; off_seen = '0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      slv_ack = '0;
      set_exp(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int c = 2; c <= d + 2; c++) begin
         @(posedge clk); #1;
         if (cpu_ready && rc == 0) begin
            rc = c; rd = cpu_rdata; er = cpu_err;
         end
         if (c == 2) off_seen = slv_addr;
         // Request stays up until ready; other fields wander to prove they are ignored.
         cpu_req   = (c <= d);
         cpu_we    = 1'($urandom);
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         slv_ack   = '0;
         for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = $urandom;
         if (!miss && c <= d) begin
            slv_ack = noise_all ? 4'hF : 4'($urandom);
            slv_ack[s] = 1'b0;
            if (c == d && !tmo) begin
               slv_ack[s] = 1'b1;
               slv_rdata[s*32 +: 32] = rdv;
            end
            set_exp(4'(1 << s), 1'b1, we, off, wdata, 1'b0);
         end else begin
            set_exp(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, c == d + 1);
         end
      end
      slv_ack = '0;
   endtask

   initial begin
      int          rc;
      logic [31:0] rd, off;
      logic        er;
      int          r;
      logic [31:0] a;

      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      slv_ack = '0; slv_rdata = '0; noise_all = 1'b0; ovl_addr = '0;
      set_exp(4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Read of slave 2, ack in the first ACCESS cycle.
      run_txn(1'b0, 32'hFFFF_F070, 32'h0, 32'h00A5_A5A5, 0, rc, rd, er, off);
      check("rd_lat", 64'(rc), 64'(3));
      check("rd_data", 64'(rd), 64'(32'h00A5_A5A5));
      check("rd_err", 64'(er), 64'(0));

      // Write to slave 3 with a late ack.
      run_txn(1'b1, 32'h0000_4008, 32'h1234_5678, 32'hDEAD_BEEF, 4, rc, rd, er, off);
      check("wr_off", 64'(off), 64'(32'h8));
      check("wr_lat", 64'(rc), 64'(7));
      check("wr_data", 64'(rd), 64'(0));
      check("wr_err", 64'(er), 64'(0));

      // Unmapped read.
      run_txn(1'b0, 32'h8000_0000, 32'h0, 32'h1111_1111, 0, rc, rd, er, off);
      check("um_lat", 64'(rc), 64'(2));
      check("um_err", 64'(er), 64'(1));
      check("um_data", 64'(rd), 64'(0));

      // Slave 0 pending while every other slave acks.
      noise_all = 1'b1;
      run_txn(1'b0, 32'hFFFF_F000, 32'h0, 32'hCAFE_F00D, 5, rc, rd, er, off);
      noise_all = 1'b0;
      check("noise_lat", 64'(rc), 64'(8));
      check("noise_data", 64'(rd), 64'(32'hCAFE_F00D));

      // Reset in the middle of ACCESS to slave 1.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F062; cpu_wdata = 32'hA5A5_0001;
      set_exp(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int c = 2; c <= 3; c++) begin
         @(posedge clk); #1;
         set_exp(4'b0010, 1'b1, 1'b1, 32'h2, 32'hA5A5_0001, 1'b0);
      end
      rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      set_exp(4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk_slv = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      run_txn(1'b0, 32'hFFFF_F060, 32'h0, 32'h0BAD_CAFE, 1, rc, rd, er, off);
      check("post_rst_lat", 64'(rc), 64'(4));
      check("post_rst_data", 64'(rd), 64'(32'h0BAD_CAFE));

`ifdef BUS_FABRIC_TIMEOUT_EN
      run_txn(1'b0, 32'hFFFF_F070, 32'h0, 32'h7777_0015, TMO - 1, rc, rd, er, off);
      check("tmo_edge_lat", 64'(rc), 64'(TMO + 2));
      check("tmo_edge_err", 64'(er), 64'(0));
      run_txn(1'b0, 32'hFFFF_F070, 32'h0, 32'h7777_0016, 1000, rc, rd, er, off);
      check("tmo_lat", 64'(rc), 64'(TMO + 2));
      check("tmo_err", 64'(er), 64'(1));
`endif

      // Randomized traffic across all regions and unmapped space.
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 4);
         a = (r < 4) ? (base_tab[r] | ($urandom & ~mask_tab[r])) : $urandom;
         run_txn(1'($urandom), a, $urandom, $urandom, $urandom_range(0, 6), rc, rd, er, off);
      end

      // Priority among overlapping regions.
      ovl_addr = 32'h0000_1010; #1;
      check("ovl_sel0", 64'(ovl_sel), 64'(3'b001));
      ovl_addr = 32'h0000_1200; #1;
      check("ovl_sel1", 64'(ovl_sel), 64'(3'b010));
      ovl_addr = 32'h0000_9000; #1;
      check("ovl_sel2", 64'(ovl_sel), 64'(3'b100));
      check("ovl_hit", 64'(ovl_hit), 64'(1));

      repeat (2) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
